// File: rtl/tdes_ahb_master_if.sv
// AHB-Lite bus bundle between the TDES job initiator and the TDES slave.
//   master modport : drives address/control/write data, receives HREADY/HRESP/HRDATA
//   slave  modport : mirror image, used by a slave model or bus fabric
interface tdes_ahb_master_if;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [63:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [63:0] HRDATA;

  modport master (
    output HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/tdes_ahb_master.sv
// AHB-Lite initiator for one Triple DES job. On a start pulse in IDLE it
// latches mode/keys/data, writes mode, key1, key2, key3, data to
// ADDR_BASE+0..4, waits RESULT_WAIT idle cycles, reads ADDR_BASE+5 and
// returns the word on result with a one-cycle done pulse.
// Ports:
//   HCLK, HRESET           clock, asynchronous active-low reset
//   start                  job request, sampled only while idle
//   mode, key1..3, dataIn  job contents
//   busy                   high while a job is in flight
//   done                   one-cycle pulse when result is valid
//   error                  sticky HRESP error flag, cleared by the next start
//   result                 last read data
//   ahb                    AHB-Lite master bus (tdes_ahb_master_if.master)
module tdes_ahb_master #(
  parameter logic [31:0] ADDR_BASE   = 32'hAAAAAAA0,
  parameter int unsigned RESULT_WAIT = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic              mode,
  input  logic [63:0]       key1,
  input  logic [63:0]       key2,
  input  logic [63:0]       key3,
  input  logic [63:0]       dataIn,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [63:0]       result,
  tdes_ahb_master_if.master ahb
);

  localparam int unsigned CNT_W = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WLAST, S_WAIT, S_RADDR, S_RDATA
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       index_q, index_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      hwdata_q, hwdata_d;
  logic [63:0]      result_q, result_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             mode_q;
  logic [63:0]      key1_q, key2_q, key3_q, data_q;
  logic             job_load;
  logic [63:0]      wword;
  logic             dphase_end;
  logic             resp_err;

  assign job_load = (state_q == S_IDLE) && start;

  // Job contents carry no reset: they are only consumed after a load.
  always_ff @(posedge HCLK) begin
    if (job_load) begin
      mode_q <= mode;
      key1_q <= key1;
      key2_q <= key2;
      key3_q <= key3;
      data_q <= dataIn;
    end
  end

  always_comb begin
    wword = data_q;
    case (index_q)
      3'd0:    wword = {63'b0, mode_q};
      3'd1:    wword = key1_q;
      3'd2:    wword = key2_q;
      3'd3:    wword = key3_q;
      default: wword = data_q;
    endcase
  end

  // A data phase is in flight during WADDR once the first address has been
  // accepted, and always in WLAST and RDATA.
  assign dphase_end = ahb.HREADY &&
                      (((state_q == S_WADDR) && (index_q != 3'd0)) ||
                       (state_q == S_WLAST) || (state_q == S_RDATA));
  assign resp_err   = dphase_end && ahb.HRESP;

  // State register
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q  <= S_IDLE;
      index_q  <= '0;
      cnt_q    <= '0;
      hwdata_q <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      cnt_q    <= cnt_d;
      hwdata_q <= hwdata_d;
      result_q <= result_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    cnt_d    = cnt_q;
    hwdata_d = hwdata_q;
    result_d = result_q;
    done_d   = 1'b0;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          index_d = '0;
          state_d = S_WADDR;
        end
      end
      S_WADDR: begin
        if (ahb.HREADY) begin
          hwdata_d = wword;
          if (index_q == 3'd4) begin
            state_d = S_WLAST;
          end else begin
            index_d = index_q + 3'd1;
          end
        end
      end
      S_WLAST: begin
        if (ahb.HREADY) begin
          if (RESULT_WAIT == 0) begin
            state_d = S_RADDR;
          end else begin
            // Loaded with N-1 so that exactly N cycles are spent in WAIT.
            cnt_d   = CNT_W'(RESULT_WAIT - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RADDR;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RADDR: begin
        if (ahb.HREADY) begin
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        if (ahb.HREADY) begin
          result_d = ahb.HRDATA;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // An error response abandons the job wherever it lands.
    if (resp_err) begin
      state_d  = S_IDLE;
      index_d  = '0;
      hwdata_d = hwdata_q;
      result_d = result_q;
      done_d   = 1'b0;
      error_d  = 1'b1;
    end
  end

  // Output logic
  always_comb begin
    ahb.HSIZE     = 3'b011;
    ahb.HBURST    = 3'b000;
    ahb.HPROT     = 4'h3;
    ahb.HMASTLOCK = 1'b0;
    ahb.HWDATA    = hwdata_q;
    ahb.HTRANS    = 2'b00;
    ahb.HWRITE    = 1'b0;
    ahb.HADDR     = 32'h0;
    case (state_q)
      S_WADDR: begin
        ahb.HTRANS = 2'b10;
        ahb.HWRITE = 1'b1;
        ahb.HADDR  = ADDR_BASE + 32'(index_q);
      end
      S_WLAST, S_WAIT: ahb.HADDR = ADDR_BASE + 32'(index_q);
      S_RADDR: begin
        ahb.HTRANS = 2'b10;
        ahb.HADDR  = ADDR_BASE + 32'd5;
      end
      S_RDATA: ahb.HADDR = ADDR_BASE + 32'd5;
      default: ;
    endcase
    busy   = (state_q != S_IDLE);
    done   = done_q;
    error  = error_q;
    result = result_q;
  end

endmodule
